pipe_ctrl_unit: RTL and testbench
=================================

// Module: pipe_ctrl_unit
// PURPOSE
//  Decode plus control-pipeline block for the 5-stage MIPS core.
//  - Decodes the ID-stage instruction into a control bundle.
//  - Carries the bundle through ID/EX, EX/MEM and MEM/WB registers.
//  - Detects load-use hazards and stalls for them.
//  - Squashes wrong-path instructions on a taken branch or a jump.
//  - Flags illegal opcodes and keeps saturating stall and flush counters.
//  - Supersedes the single-cycle combinational decoder.
// PARAMETERS
//  INSTR_W     32  instruction width; opcode = instr[INSTR_W-1 -: 6]
//  REG_ADDR_W  5   register-specifier width
//  CNT_W       16  width of the perf counters (saturating)
//  ENABLE_EXT  1   1: decode ADDI/SLTI/ORI; 0: these are illegal
// PORTS
//  clk            in   1           core clock
//  rst            in   1           synchronous, active-high reset
//  id_instr       in   INSTR_W     instruction in the ID stage
//  ex_br_taken    in   1           EX-stage BEQ resolved taken (from datapath zero flag)
//  pc_write       out  1           0 = hold PC (stall)
//  ifid_write     out  1           0 = hold IF/ID (stall)
//  ifid_flush     out  1           1 = load IF/ID with nop on next edge
//  id_jump        out  1           ID holds a J; PC <- jump target
//  id_illegal     out  1           ID opcode undefined (combinational)
//  ex_alu_op      out  3           ALU op for the EX stage
//  ex_alu_src     out  1           EX ALU operand select
//  ex_reg_dst     out  1           EX destination-register select
//  ex_branch      out  1           EX instruction is a BEQ
//  mem_read       out  1           MEM-stage load
//  mem_write      out  1           MEM-stage store
//  wb_reg_write   out  1           WB-stage register write
//  wb_mem_to_reg  out  1           WB result select (1 = memory)
//  stall_cnt      out  CNT_W       number of load-use stall cycles
//  flush_cnt      out  CNT_W       number of squashed instructions
// BEHAVIOUR
//  Opcodes: R=0 J=2 BEQ=4 ADDI=8 SLTI=10 ANDI=12 ORI=13 LW=35 SW=43.
//  ALU ops: ADD=000 SUB=001 FUNCT=010 AND=011 OR=100 SLT=101.
//  Decode (combinational, ID):
//   R:    reg_dst, reg_write, op FUNCT
//   LW:   alu_src, mem_read, reg_write, mem_to_reg, op ADD
//   SW:   alu_src, mem_write, op ADD
//   BEQ:  branch, op SUB
//   J:    id_jump; bundle = bubble
//   ADDI/SLTI/ANDI/ORI: alu_src, reg_write, op ADD/SLT/AND/OR
//  Bubble = all control bits 0 and op ADD.
//  id_instr == 0 decodes as a bubble: not illegal, not counted.
//  Undefined opcode: id_illegal=1 and bundle = bubble (never X).
//  Latency: the ID bundle appears on ex_* 1 edge later, mem_* after 2, wb_* after 3.
//  Load-use hazard (hz), evaluated combinationally in ID:
//   - Condition: ID/EX.mem_read AND ID/EX.rt != 0 AND
//     (ID/EX.rt == id rs OR (ID reads rt AND ID/EX.rt == id rt)).
//   - ID reads rt for: R, BEQ, SW.
//   - On hz: pc_write=0, ifid_write=0, ID/EX loads a bubble, stall_cnt++.
//  Taken branch (ex_br_taken=1):
//   - ID/EX loads a bubble; ifid_flush=1.
//   - pc_write=1 so the branch target is fetched.
//   - Overrides hz: stall outputs deasserted; stall_cnt not incremented.
//   - flush_cnt += 2.
//  Jump (id_jump=1, no ex_br_taken):
//   - ifid_flush=1; flush_cnt += 1.
//   - If hz and jump coincide, hz wins; the jump retries next cycle.
//  Counters saturate at all-ones; no wrap-around.
//  EX/MEM and MEM/WB always advance; they never stall.
//  Reset (any cycle, including mid-stall or mid-flush), at the next edge:
//   - All stage registers = bubble; counters = 0.
//   - Reset values: pc_write=1, ifid_write=1, ifid_flush=0; all ex_/mem_/wb_ outputs 0.
// STRUCTURE
//  Package pipe_ctrl_pkg:
//   - opcode localparams, ALU-op encodings
//   - ctrl_t struct {alu_op, alu_src, reg_dst, branch, mem_read, mem_write, reg_write, mem_to_reg}
//   - BUBBLE constant
//  Sub-module ctrl_decode: combinational; id_instr -> ctrl_t, id_jump, id_illegal.
//  Top level holds the stage registers, hazard/flush logic and counters.
// TESTING
//  1. LW r2,0(r1) then ADD r3,r2,r4
//     -> 1 stall cycle (pc_write=0, ifid_write=0), bubble on ex_*, stall_cnt=1.
//  2. LW r0,.. then ADD r3,r0,r4 -> no stall; stall_cnt=0.
//  3. BEQ in EX with ex_br_taken=1 while a load-use stall is pending
//     -> ifid_flush=1, pc_write=1, stall_cnt unchanged, flush_cnt=2.
//  4. Opcode 6'd63 -> id_illegal=1, ex_* bubble 1 cycle later.
//     With ENABLE_EXT=0, ORI also -> id_illegal=1.
//  5. CNT_W=2, 5 load-use stalls -> stall_cnt holds at 3.
//  6. Assert rst mid-stall -> next edge: all outputs at reset values,
//     counters 0; a following LW reaches wb_mem_to_reg=1 exactly 3 edges after decode.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: opcodes, ALU-op encodings and the control bundle shared by the pipeline control unit
package pipe_ctrl_pkg;
  localparam logic [5:0] OP_R = 6'd0, OP_J = 6'd2, OP_BEQ = 6'd4, OP_ADDI = 6'd8, OP_SLTI = 6'd10;
  localparam logic [5:0] OP_ANDI = 6'd12, OP_ORI = 6'd13, OP_LW = 6'd35, OP_SW = 6'd43;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011, ALU_OR = 3'b100, ALU_SLT = 3'b101;
  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;
  localparam ctrl_t BUBBLE = '{alu_op: ALU_ADD, default: 1'b0};
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational ID-stage decoder
//   instr -> ctrl (control bundle), jump (J in ID), illegal (undefined opcode),
//   reads_rt (instruction sources rt: R, BEQ, SW)
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter bit ENABLE_EXT = 1
) (
  input  logic [INSTR_W-1:0] instr,
  output ctrl_t              ctrl,
  output logic               jump,
  output logic               illegal,
  output logic               reads_rt
);
  logic [5:0] op;
  assign op = instr[INSTR_W-1 -: 6];
  always_comb begin
    ctrl = BUBBLE;
    jump = 1'b0;
    illegal = 1'b0;
    reads_rt = 1'b0;
    if (instr != '0) begin
      case (op)
        OP_R:    begin ctrl.reg_dst = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_FUNCT; reads_rt = 1'b1; end
        OP_LW:   begin ctrl.alu_src = 1'b1; ctrl.mem_read = 1'b1; ctrl.reg_write = 1'b1; ctrl.mem_to_reg = 1'b1; end
        OP_SW:   begin ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; reads_rt = 1'b1; end
        OP_BEQ:  begin ctrl.branch = 1'b1; ctrl.alu_op = ALU_SUB; reads_rt = 1'b1; end
        OP_J:    jump = 1'b1;
        OP_ANDI: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_AND; end
        OP_ADDI, OP_SLTI, OP_ORI:
          if (ENABLE_EXT) begin
            ctrl.alu_src = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op = op == OP_SLTI ? ALU_SLT : op == OP_ORI ? ALU_OR : ALU_ADD;
          end else illegal = 1'b1;
        default: illegal = 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: decode, ID/EX-EX/MEM-MEM/WB control pipeline, load-use stall, branch/jump squash, perf counters
//   in : clk, rst (sync, active-high), id_instr, ex_br_taken
//   out: pc_write, ifid_write, ifid_flush, id_jump, id_illegal,
//        ex_alu_op, ex_alu_src, ex_reg_dst, ex_branch, mem_read, mem_write,
//        wb_reg_write, wb_mem_to_reg, stall_cnt, flush_cnt
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16,
  parameter bit ENABLE_EXT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] id_instr,
  input  logic               ex_br_taken,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               ifid_flush,
  output logic               id_jump,
  output logic               id_illegal,
  output logic [2:0]         ex_alu_op,
  output logic               ex_alu_src,
  output logic               ex_reg_dst,
  output logic               ex_branch,
  output logic               mem_read,
  output logic               mem_write,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);
  ctrl_t                  dec, idex;
  logic [REG_ADDR_W-1:0]  idex_rt, rs, rt;
  logic                   reads_rt, hz, stall;
  logic [3:0]             exmem;
  logic [1:0]             memwb;
  logic [CNT_W:0]         s_sum, f_sum;
  ctrl_decode #(.INSTR_W(INSTR_W), .ENABLE_EXT(ENABLE_EXT)) u_dec (
    .instr(id_instr), .ctrl(dec), .jump(id_jump), .illegal(id_illegal), .reads_rt(reads_rt)
  );
  assign rs = id_instr[INSTR_W-7 -: REG_ADDR_W];
  assign rt = id_instr[INSTR_W-7-REG_ADDR_W -: REG_ADDR_W];
  assign hz = idex.mem_read && idex_rt != '0 && (idex_rt == rs || (reads_rt && idex_rt == rt));
  // a taken branch squashes the stalled instruction anyway, so it cancels the stall
  assign stall = hz && !ex_br_taken;
  assign pc_write = !stall;
  assign ifid_write = !stall;
  assign ifid_flush = ex_br_taken || (id_jump && !hz);
  // one extra bit catches overflow so the counters clamp at all-ones
  assign s_sum = {1'b0, stall_cnt} + (CNT_W+1)'(stall);
  assign f_sum = {1'b0, flush_cnt} + (ex_br_taken ? (CNT_W+1)'(2) : (CNT_W+1)'(id_jump && !hz));
  assign ex_alu_op = idex.alu_op;
  assign ex_alu_src = idex.alu_src;
  assign ex_reg_dst = idex.reg_dst;
  assign ex_branch = idex.branch;
  assign {mem_read, mem_write} = exmem[3:2];
  assign {wb_reg_write, wb_mem_to_reg} = memwb;
  always_ff @(posedge clk) begin
    if (rst) begin
      idex <= BUBBLE;
      idex_rt <= '0;
      exmem <= '0;
      memwb <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      idex <= (hz || ex_br_taken) ? BUBBLE : dec;
      idex_rt <= (hz || ex_br_taken) ? '0 : rt;
      exmem <= {idex.mem_read, idex.mem_write, idex.reg_write, idex.mem_to_reg};
      memwb <= exmem[1:0];
      stall_cnt <= s_sum[CNT_W] ? '1 : s_sum[CNT_W-1:0];
      flush_cnt <= f_sum[CNT_W] ? '1 : f_sum[CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed self-checking bench for pipe_ctrl_unit (default and CNT_W=2/ENABLE_EXT=0 instances)
module tb_pipe_ctrl_unit;
  logic clk = 0, rst = 1, br = 0;
  logic [31:0] instr = 0;
  logic pc_write, ifid_write, ifid_flush, id_jump, id_illegal, ex_alu_src, ex_reg_dst, ex_branch;
  logic mem_read, mem_write, wb_reg_write, wb_mem_to_reg;
  logic [2:0] ex_alu_op;
  logic [15:0] stall_cnt, flush_cnt;
  logic s_pc_write, s_ifid_write, s_ifid_flush, s_id_jump, s_id_illegal, s_ex_alu_src, s_ex_reg_dst, s_ex_branch;
  logic s_mem_read, s_mem_write, s_wb_reg_write, s_wb_mem_to_reg;
  logic [2:0] s_ex_alu_op;
  logic [1:0] s_stall_cnt, s_flush_cnt;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  pipe_ctrl_unit dut (
    .clk(clk), .rst(rst), .id_instr(instr), .ex_br_taken(br), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .id_jump(id_jump), .id_illegal(id_illegal), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst), .ex_branch(ex_branch), .mem_read(mem_read),
    .mem_write(mem_write), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  pipe_ctrl_unit #(.CNT_W(2), .ENABLE_EXT(0)) sml (
    .clk(clk), .rst(rst), .id_instr(instr), .ex_br_taken(br), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
    .ifid_flush(s_ifid_flush), .id_jump(s_id_jump), .id_illegal(s_id_illegal), .ex_alu_op(s_ex_alu_op),
    .ex_alu_src(s_ex_alu_src), .ex_reg_dst(s_ex_reg_dst), .ex_branch(s_ex_branch), .mem_read(s_mem_read),
    .mem_write(s_mem_write), .wb_reg_write(s_wb_reg_write), .wb_mem_to_reg(s_wb_mem_to_reg),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );
  function automatic logic [31:0] itp(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, 16'd4};
  endfunction
  function automatic logic [31:0] rtp(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, 6'd32};
  endfunction
  task automatic tick; @(posedge clk); #1; endtask
  task automatic drive(input logic [31:0] i, input logic b); instr = i; br = b; #1; endtask
  task automatic do_reset; rst = 1; drive(0, 0); tick; rst = 0; endtask
  task automatic test_reset;
    do_reset;
    total++; if ({pc_write, ifid_write, ifid_flush} !== 3'b110) begin bad++; $display("FAIL reset_hz got %b want 110", {pc_write, ifid_write, ifid_flush}); end
    total++; if ({ex_alu_op, ex_alu_src, ex_reg_dst, ex_branch, mem_read, mem_write, wb_reg_write, wb_mem_to_reg} !== 10'd0) begin bad++; $display("FAIL reset_stages got %b want 0", {ex_alu_op, ex_alu_src, ex_reg_dst, ex_branch, mem_read, mem_write, wb_reg_write, wb_mem_to_reg}); end
    total++; if ({stall_cnt, flush_cnt} !== 32'd0) begin bad++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
  endtask
  task automatic test_load_use;
    do_reset;
    drive(itp(35, 1, 2), 0); tick;
    drive(rtp(2, 4, 3), 0);
    total++; if ({pc_write, ifid_write} !== 2'b00) begin bad++; $display("FAIL lu_stall got %b want 00", {pc_write, ifid_write}); end
    tick;
    total++; if ({ex_alu_op, ex_alu_src, ex_reg_dst, ex_branch} !== 6'd0) begin bad++; $display("FAIL lu_bubble got %b want 0", {ex_alu_op, ex_alu_src, ex_reg_dst, ex_branch}); end
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt got %0d want 1", stall_cnt); end
    total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL lu_memrd got %b want 1", mem_read); end
    total++; if (pc_write !== 1'b1) begin bad++; $display("FAIL lu_release got %b want 1", pc_write); end
    tick;
    total++; if ({ex_alu_op, ex_reg_dst} !== 4'b0101) begin bad++; $display("FAIL lu_add_ex got %b want 0101", {ex_alu_op, ex_reg_dst}); end
    total++; if ({wb_reg_write, wb_mem_to_reg, stall_cnt} !== {2'b11, 16'd1}) begin bad++; $display("FAIL lu_wb got %b/%0d want 11/1", {wb_reg_write, wb_mem_to_reg}, stall_cnt); end
  endtask
  task automatic test_load_r0;
    do_reset;
    drive(itp(35, 1, 0), 0); tick;
    drive(rtp(0, 4, 3), 0);
    total++; if (pc_write !== 1'b1) begin bad++; $display("FAIL r0_nostall got %b want 1", pc_write); end
    tick;
    total++; if ({stall_cnt, ex_reg_dst} !== {16'd0, 1'b1}) begin bad++; $display("FAIL r0_cnt got %0d/%b want 0/1", stall_cnt, ex_reg_dst); end
  endtask
  task automatic test_branch_flush;
    do_reset;
    drive(itp(35, 1, 2), 0); tick;
    drive(rtp(2, 4, 3), 1);
    total++; if ({ifid_flush, pc_write, ifid_write} !== 3'b111) begin bad++; $display("FAIL br_ctl got %b want 111", {ifid_flush, pc_write, ifid_write}); end
    tick;
    total++; if ({stall_cnt, flush_cnt} !== {16'd0, 16'd2}) begin bad++; $display("FAIL br_cnt got %0d/%0d want 0/2", stall_cnt, flush_cnt); end
    total++; if ({ex_alu_op, ex_alu_src, ex_reg_dst} !== 5'd0) begin bad++; $display("FAIL br_bubble got %b want 0", {ex_alu_op, ex_alu_src, ex_reg_dst}); end
    drive({6'd2, 26'd100}, 0);
    total++; if ({id_jump, ifid_flush} !== 2'b11) begin bad++; $display("FAIL j_ctl got %b want 11", {id_jump, ifid_flush}); end
    tick;
    total++; if ({flush_cnt, ex_alu_op, ex_alu_src} !== {16'd3, 4'd0}) begin bad++; $display("FAIL j_cnt got %0d/%b want 3/0", flush_cnt, {ex_alu_op, ex_alu_src}); end
    drive(itp(35, 1, 2), 0); tick;
    drive({6'd2, 5'd2, 21'd0}, 0);
    total++; if ({id_jump, ifid_flush, pc_write} !== 3'b100) begin bad++; $display("FAIL jhz_ctl got %b want 100", {id_jump, ifid_flush, pc_write}); end
    tick;
    total++; if ({flush_cnt, stall_cnt, ifid_flush} !== {16'd3, 16'd1, 1'b1}) begin bad++; $display("FAIL jhz_retry got %0d/%0d/%b want 3/1/1", flush_cnt, stall_cnt, ifid_flush); end
    tick;
    total++; if (flush_cnt !== 16'd4) begin bad++; $display("FAIL jhz_cnt got %0d want 4", flush_cnt); end
  endtask
  task automatic test_illegal;
    do_reset;
    drive(itp(8, 1, 2), 0);
    total++; if ({id_illegal, s_id_illegal} !== 2'b01) begin bad++; $display("FAIL addi_ill got %b want 01", {id_illegal, s_id_illegal}); end
    tick;
    drive({6'd63, 26'd0}, 0);
    total++; if ({id_illegal, s_id_illegal, ex_alu_src} !== 3'b111) begin bad++; $display("FAIL op63_ill got %b want 111", {id_illegal, s_id_illegal, ex_alu_src}); end
    tick;
    total++; if ({ex_alu_op, ex_alu_src, ex_reg_dst, ex_branch} !== 6'd0) begin bad++; $display("FAIL op63_ex got %b want 0", {ex_alu_op, ex_alu_src, ex_reg_dst, ex_branch}); end
    drive(itp(13, 1, 2), 0);
    total++; if ({id_illegal, s_id_illegal} !== 2'b01) begin bad++; $display("FAIL ori_ill got %b want 01", {id_illegal, s_id_illegal}); end
    tick;
    total++; if ({ex_alu_op, ex_alu_src, s_ex_alu_op, s_ex_alu_src} !== 8'b1001_0000) begin bad++; $display("FAIL ori_ex got %b want 10010000", {ex_alu_op, ex_alu_src, s_ex_alu_op, s_ex_alu_src}); end
    drive(itp(4, 1, 2), 0); tick;
    total++; if ({ex_alu_op, ex_branch, id_illegal} !== 5'b00110) begin bad++; $display("FAIL beq_ex got %b want 00110", {ex_alu_op, ex_branch, id_illegal}); end
  endtask
  task automatic test_saturate;
    do_reset;
    for (int k = 0; k < 5; k++) begin
      drive(itp(35, 1, 2), 0); tick;
      drive(rtp(2, 4, 3), 0); tick;
    end
    total++; if ({stall_cnt, s_stall_cnt} !== {16'd5, 2'd3}) begin bad++; $display("FAIL sat_cnt got %0d/%0d want 5/3", stall_cnt, s_stall_cnt); end
    drive(0, 1); tick; tick;
    total++; if ({flush_cnt, s_flush_cnt} !== {16'd4, 2'd3}) begin bad++; $display("FAIL sat_flush got %0d/%0d want 4/3", flush_cnt, s_flush_cnt); end
  endtask
  task automatic test_reset_mid_stall;
    do_reset;
    drive(itp(35, 1, 2), 0); tick;
    drive(rtp(2, 4, 3), 0); tick;
    drive(itp(35, 1, 2), 0); tick;
    drive(rtp(2, 4, 3), 0);
    rst = 1; tick; rst = 0; #1;
    total++; if ({pc_write, ifid_write, ifid_flush} !== 3'b110) begin bad++; $display("FAIL rst_hz got %b want 110", {pc_write, ifid_write, ifid_flush}); end
    total++; if ({ex_alu_op, ex_alu_src, ex_reg_dst, ex_branch, mem_read, mem_write, wb_reg_write, wb_mem_to_reg, stall_cnt, flush_cnt} !== 42'd0) begin bad++; $display("FAIL rst_state got %b/%0d/%0d want 0", {ex_alu_op, ex_alu_src, mem_read, wb_reg_write}, stall_cnt, flush_cnt); end
    drive(itp(35, 1, 2), 0); tick;
    drive(0, 0); tick;
    total++; if ({mem_read, wb_mem_to_reg} !== 2'b10) begin bad++; $display("FAIL rst_lw2 got %b want 10", {mem_read, wb_mem_to_reg}); end
    tick;
    total++; if (wb_mem_to_reg !== 1'b1) begin bad++; $display("FAIL rst_lw3 got %b want 1", wb_mem_to_reg); end
  endtask
  initial begin
    test_reset;
    test_load_use;
    test_load_r0;
    test_branch_flush;
    test_illegal;
    test_saturate;
    test_reset_mid_stall;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
